// File: rtl/painel_modo_if.sv
// Button and panel-control bundle between the scrolling-panel front end and its
// surroundings: raw active-low buttons in, register mode code / step strobe out.
interface painel_modo_if;
   logic       btn_modo_n;
   logic       btn_carga_n;
   logic       btn_pausa_n;
   logic       ch1;
   logic       ch0;
   logic       passo;
   logic [1:0] estado;
   logic       pausado;

   modport master (
      output btn_modo_n, btn_carga_n, btn_pausa_n,
      input  ch1, ch0, passo, estado, pausado
   );

   modport slave (
      input  btn_modo_n, btn_carga_n, btn_pausa_n,
      output ch1, ch0, passo, estado, pausado
   );
endinterface

// File: rtl/painel_modo.sv
// Front-end control for the 5x7 scrolling LED panel: debounces three buttons,
// produces the row-register mode code {ch1,ch0} and the scroll-step strobe.
//
// state    | meaning
// PARADO   | registers hold (code 00)
// DIREITA  | shift right every step (code 01, 00 while paused)
// ESQUERDA | shift left every step (code 10, 00 while paused)
// CARGA    | parallel load on the next step, then return (code 11)
module painel_modo #(
   parameter int DEB_CYCLES = 50000,
   parameter int STEP_DIV   = 12500000
) (
   input logic         clk,
   input logic         rst_n,
   painel_modo_if.slave bus
);

   localparam int DEB_W  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam int STEP_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(DEB_CYCLES - 1);
   localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(STEP_DIV - 1);

   localparam logic [1:0] PARADO   = 2'b00;
   localparam logic [1:0] DIREITA  = 2'b01;
   localparam logic [1:0] ESQUERDA = 2'b10;
   localparam logic [1:0] CARGA    = 2'b11;

   // button index: 0 = modo, 1 = carga, 2 = pausa
   logic [2:0] w_btn_raw;
   logic [2:0] r_sync1;
   logic [2:0] r_sync2;
   logic [2:0] r_deb;
   logic [2:0] r_press;

   logic [1:0]        r_estado;
   logic              r_pausado;
   logic [1:0]        r_ch;
   logic              r_passo;
   logic [STEP_W-1:0] r_step;
   logic              r_ret_parado;
   logic [1:0]        r_dir;

   logic [1:0]        w_estado_nxt;
   logic              w_pausado_nxt;
   logic              w_ret_parado_nxt;
   logic [1:0]        w_dir_nxt;
   logic [1:0]        w_ch_nxt;
   logic              w_step_run;
   logic              w_run_nxt;
   logic [STEP_W-1:0] w_step_nxt;
   logic              w_ev_modo;
   logic              w_ev_carga;
   logic              w_ev_pausa;

   assign w_btn_raw = {bus.btn_pausa_n, bus.btn_carga_n, bus.btn_modo_n};

   // two-flop synchronizer; released (1) out of reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 3'b111;
         r_sync2 <= 3'b111;
      end else begin
         r_sync1 <= w_btn_raw;
         r_sync2 <= r_sync1;
      end
   end

   for (genvar g = 0; g < 3; g++) begin : g_deb
      logic [DEB_W-1:0] r_cnt;

      // count disagreeing cycles; flip the level and flag a press on 1->0
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_cnt      <= '0;
            r_deb[g]   <= 1'b1;
            r_press[g] <= 1'b0;
         end else begin
            r_press[g] <= 1'b0;
            if (r_sync2[g] != r_deb[g]) begin
               if (r_cnt == DEB_MAX) begin
                  r_cnt      <= '0;
                  r_deb[g]   <= r_sync2[g];
                  r_press[g] <= ~r_sync2[g];
               end else begin
                  r_cnt <= r_cnt + DEB_W'(1);
               end
            end else begin
               r_cnt <= '0;
            end
         end
      end
   end

   assign w_ev_modo  = r_press[0];
   assign w_ev_carga = r_press[1];
   assign w_ev_pausa = r_press[2];

   // next state, pause flag and return bookkeeping; carga > modo > pausa
   always_comb begin
      w_estado_nxt     = r_estado;
      w_pausado_nxt    = r_pausado;
      w_ret_parado_nxt = r_ret_parado;
      w_dir_nxt        = r_dir;
      if (r_estado == CARGA) begin
         // the return target is PARADO or the last direction entered
         if (r_passo) begin
            w_estado_nxt = r_ret_parado ? PARADO : r_dir;
         end
      end else if (w_ev_carga) begin
         w_ret_parado_nxt = (r_estado == PARADO);
         w_estado_nxt     = CARGA;
      end else if (w_ev_modo) begin
         case (r_estado)
            PARADO: begin
               w_estado_nxt = DIREITA;
               w_dir_nxt    = DIREITA;
            end
            DIREITA: begin
               w_estado_nxt = ESQUERDA;
               w_dir_nxt    = ESQUERDA;
            end
            default: w_estado_nxt = PARADO;
         endcase
      end
      if (w_ev_pausa && !w_ev_carga && !w_ev_modo) begin
         w_pausado_nxt = ~r_pausado;
      end
   end

   // mode code follows the next state; a paused shift becomes hold
   always_comb begin
      w_ch_nxt = w_estado_nxt;
      if (w_pausado_nxt && (w_estado_nxt == DIREITA || w_estado_nxt == ESQUERDA)) begin
         w_ch_nxt = PARADO;
      end
   end

   // step counter advances unless paused outside CARGA; strobe marks its last count
   always_comb begin
      w_step_run = !r_pausado || (r_estado == CARGA);
      w_run_nxt  = !w_pausado_nxt || (w_estado_nxt == CARGA);
      w_step_nxt = r_step;
      if (w_step_run) begin
         w_step_nxt = (r_step == STEP_MAX) ? '0 : r_step + STEP_W'(1);
      end
   end

   // registered state and outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_estado     <= PARADO;
         r_pausado    <= 1'b0;
         r_ch         <= 2'b00;
         r_passo      <= 1'b0;
         r_step       <= '0;
         r_ret_parado <= 1'b1;
         r_dir        <= DIREITA;
      end else begin
         r_estado     <= w_estado_nxt;
         r_pausado    <= w_pausado_nxt;
         r_ch         <= w_ch_nxt;
         r_passo      <= w_run_nxt && (w_step_nxt == STEP_MAX);
         r_step       <= w_step_nxt;
         r_ret_parado <= w_ret_parado_nxt;
         r_dir        <= w_dir_nxt;
      end
   end

   assign bus.ch1     = r_ch[1];
   assign bus.ch0     = r_ch[0];
   assign bus.passo   = r_passo;
   assign bus.estado  = r_estado;
   assign bus.pausado = r_pausado;

endmodule

// File: tb/tb_painel_modo.sv
// Directed bench for painel_modo with DEB_CYCLES=4, STEP_DIV=8.
module tb_painel_modo;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   painel_modo_if bus();

   painel_modo #(.DEB_CYCLES(4), .STEP_DIV(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;
   int cyc     = 0;
   int last_passo = -1;

   typedef struct {
      logic [2:0] btn;      // bit0 modo, bit1 carga, bit2 pausa
      int         low;
      logic [1:0] e_estado;
      logic [1:0] e_ch;
      logic       e_paus;
   } vec_t;

   vec_t tbl[9];

   always @(posedge clk) cyc++;
   always @(negedge clk) if (bus.passo) last_passo = cyc;

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic set_btns(input logic [2:0] m);
      bus.btn_modo_n  = ~m[0];
      bus.btn_carga_n = ~m[1];
      bus.btn_pausa_n = ~m[2];
   endtask

   task automatic press(input logic [2:0] m, input int low);
      @(posedge clk); #1;
      set_btns(m);
      repeat (low) @(posedge clk);
      #1;
      set_btns(3'b000);
      repeat (12) @(posedge clk);
      #1;
   endtask

   task automatic check_state(input string name, input int e_est, input int e_ch, input int e_p);
      chk({name, " estado"}, int'(bus.estado), e_est);
      chk({name, " ch"}, int'({bus.ch1, bus.ch0}), e_ch);
      chk({name, " pausado"}, int'(bus.pausado), e_p);
   endtask

   task automatic do_carga(input logic [2:0] m, input int ret, input string name);
      bit found;
      found = 0;
      @(posedge clk); #1;
      set_btns(m);
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         if (bus.estado == 2'b11) begin found = 1; break; end
      end
      chk({name, " carga entered"}, int'(found), 1);
      if (found) begin
         chk({name, " ch in carga"}, int'({bus.ch1, bus.ch0}), 3);
         found = 0;
         for (int k = 0; k < 20; k++) begin
            if (bus.passo) begin found = 1; break; end
            chk({name, " ch holds 11"}, int'({bus.ch1, bus.ch0}), 3);
            @(posedge clk); #1;
         end
         chk({name, " load step seen"}, int'(found), 1);
         chk({name, " ch with passo"}, int'({bus.ch1, bus.ch0}), 3);
         chk({name, " estado with passo"}, int'(bus.estado), 3);
         @(posedge clk); #1;
         chk({name, " return estado"}, int'(bus.estado), ret);
         chk({name, " return ch"}, int'({bus.ch1, bus.ch0}), ret);
      end
      set_btns(3'b000);
      repeat (12) @(posedge clk);
      #1;
   endtask

   initial begin
      int p_edge, r_edge, lp, c, n_pa, exp_edge, got_edge;
      bit found;

      tbl[0] = '{3'b001, 3,  2'b00, 2'b00, 1'b0};  // bounce: ignored
      tbl[1] = '{3'b001, 10, 2'b01, 2'b01, 1'b0};
      tbl[2] = '{3'b001, 10, 2'b10, 2'b10, 1'b0};
      tbl[3] = '{3'b100, 10, 2'b10, 2'b00, 1'b1};
      tbl[4] = '{3'b100, 10, 2'b10, 2'b10, 1'b0};
      tbl[5] = '{3'b001, 10, 2'b00, 2'b00, 1'b0};
      tbl[6] = '{3'b100, 10, 2'b00, 2'b00, 1'b1};
      tbl[7] = '{3'b001, 10, 2'b01, 2'b00, 1'b1};
      tbl[8] = '{3'b100, 10, 2'b01, 2'b01, 1'b0};

      set_btns(3'b000);
      repeat (3) @(posedge clk);
      #1;
      check_state("reset", 0, 0, 0);
      chk("reset passo", int'(bus.passo), 0);

      // idle after reset: strobe every 8 cycles, first on the 7th edge
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         chk($sformatf("idle passo k=%0d", k), int'(bus.passo), (k % 8 == 7) ? 1 : 0);
      end
      check_state("idle", 0, 0, 0);

      for (int i = 0; i < 9; i++) begin
         press(tbl[i].btn, tbl[i].low);
         check_state($sformatf("vec%0d", i), int'(tbl[i].e_estado), int'(tbl[i].e_ch),
                     int'(tbl[i].e_paus));
      end

      // load from DIREITA, then from PARADO
      do_carga(3'b010, 1, "carga dir");
      check_state("after carga dir", 1, 1, 0);
      press(3'b001, 10);
      press(3'b001, 10);
      check_state("back parado", 0, 0, 0);
      do_carga(3'b010, 0, "carga parado");

      // pause in ESQUERDA holds the step counter
      press(3'b001, 10);
      press(3'b001, 10);
      check_state("esq", 2, 2, 0);
      @(posedge clk); #1;
      set_btns(3'b100);
      found = 0;
      p_edge = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         if (bus.pausado) begin found = 1; p_edge = cyc; break; end
      end
      chk("pause seen", int'(found), 1);
      lp = last_passo;
      set_btns(3'b000);
      n_pa = 0;
      for (int k = 0; k < 50; k++) begin
         @(posedge clk); #1;
         if (bus.passo) n_pa++;
      end
      check_state("paused esq", 2, 0, 1);
      chk("passo while paused", n_pa, 0);
      set_btns(3'b100);
      found = 0;
      r_edge = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         if (!bus.pausado) begin found = 1; r_edge = cyc; break; end
      end
      chk("unpause seen", int'(found), 1);
      check_state("unpaused esq", 2, 2, 0);
      c = (p_edge - lp + 7) % 8;
      exp_edge = r_edge + 7 - c;
      found = 0;
      got_edge = -1;
      for (int k = 0; k < 20; k++) begin
         if (bus.passo) begin found = 1; got_edge = cyc; break; end
         @(posedge clk); #1;
      end
      chk("passo resumed", int'(found), 1);
      chk("passo resume edge", got_edge, exp_edge);
      set_btns(3'b000);
      repeat (12) @(posedge clk);
      #1;

      // carga and modo together from PARADO: modo is dropped
      press(3'b001, 10);
      check_state("parado again", 0, 0, 0);
      do_carga(3'b011, 0, "carga+modo");
      check_state("after carga+modo", 0, 0, 0);

      // asynchronous reset in the middle of CARGA
      press(3'b001, 10);
      @(posedge clk); #1;
      set_btns(3'b010);
      found = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         if (bus.estado == 2'b11) begin found = 1; break; end
      end
      chk("pre-reset carga", int'(found), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check_state("async reset", 0, 0, 0);
      chk("async reset passo", int'(bus.passo), 0);
      set_btns(3'b000);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      check_state("post reset", 0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/painel_modo.md
Name: painel_modo

Overview:
- Front-end control stage for the 5x7 scrolling LED panel; sits directly upstream of the row universal registers.
- Turns raw, bouncing push-buttons into the 2-bit register mode code {ch1,ch0} and a one-cycle scroll-step strobe.
- The strobe paces register shifting; the mode code selects hold / shift right / shift left / parallel load of the row patterns.

Parameters:
DEB_CYCLES, 50000, consecutive stable cycles required before a debounced button level changes (1 ms at 50 MHz)
STEP_DIV, 12500000, clk cycles per scroll step (4 steps/s at 50 MHz); minimum 2

Ports:
clk  input  1  system clock; single clock domain
rst_n  input  1  asynchronous active-low reset
btn_modo_n  input  1  raw button, active-low: cycle scroll mode
btn_carga_n  input  1  raw button, active-low: request pattern reload
btn_pausa_n  input  1  raw button, active-low: toggle pause
ch1  output  1  mode code MSB to row registers
ch0  output  1  mode code LSB to row registers
passo  output  1  one-cycle scroll-step strobe
estado  output  2  current FSM state, for debug LEDs
pausado  output  1  pause flag

Behaviour:
- Reset (asynchronous, rst_n=0): all flops clear. Outputs: estado=PARADO, {ch1,ch0}=00, passo=0, pausado=0. Debounced levels preset to released (1). Step counter=0, saved direction=DIREITA.
- Input conditioning (per button):
  - 2-flop synchronizer, then debounce counter.
  - Counter increments while the synced input differs from the debounced level and clears when they match.
  - On reaching DEB_CYCLES-1 the debounced level flips and the counter clears.
  - Press event = one-cycle pulse on the debounced 1->0 transition. Releases generate nothing.
- Step generator:
  - Counter runs 0..STEP_DIV-1 and wraps to 0.
  - passo=1 exactly in the cycle the counter equals STEP_DIV-1.
  - Counter holds its value while pausado=1 and estado!=CARGA.
- Pause: pausa event toggles pausado. When pausado=1 in DIREITA or ESQUERDA, {ch1,ch0} is forced to 00; the state is kept.
- FSM. States and mode code: PARADO=00 -> code 00; DIREITA=01 -> code 01; ESQUERDA=10 -> code 10; CARGA=11 -> code 11.
  - modo event: PARADO->DIREITA->ESQUERDA->PARADO. Ignored in CARGA.
  - Entering DIREITA or ESQUERDA records it as the saved direction.
  - carga event from any state except CARGA: record the return state (the current state), go to CARGA.
  - In CARGA, {ch1,ch0}=11 regardless of pausado. The step counter runs.
  - CARGA stays until the first passo; passo is asserted in that cycle with code 11, so the registers load on exactly one step. The next cycle returns to the recorded state.
  - Simultaneous events in one cycle: priority carga > modo > pausa. Lower-priority events in that cycle are dropped.
  - A carga event while already in CARGA is ignored.
- Latency: button stable low for DEB_CYCLES cycles after synchronization -> press pulse -> state/outputs change on the next clk edge.
- Outputs are registered; estado and {ch1,ch0} change together.
- Reset asserted mid-debounce or mid-CARGA aborts immediately to the reset values. No pending event survives reset.

Test Plan:
All scenarios use DEB_CYCLES=4, STEP_DIV=8.
1. Release rst_n, idle 40 cycles -> estado=00, ch=00. passo pulses every 8 cycles (first at cycle 7 after reset release). pausado=0.
2. btn_modo_n held low for 3 cycles, then high (bounce) -> no state change. Held low for 10 cycles -> exactly one transition PARADO->DIREITA, ch=01. Two more clean presses -> ESQUERDA (10), then PARADO (00).
3. In DIREITA press carga -> ch=11 until the next passo. passo asserted in the same cycle as ch=11. The following cycle ch=01, estado=01. Repeat starting from PARADO -> returns to 00.
4. In ESQUERDA press pausa -> pausado=1, ch=00, estado=10, no passo for 50 cycles. Press pausa again -> ch=10, passo resumes from the held counter value.
5. Debounced carga and modo events in the same cycle from PARADO -> CARGA entered, modo dropped. After the load step, estado=00.
6. Assert rst_n=0 asynchronously mid-CARGA (between clock edges) -> ch=00, estado=00, passo=0 immediately, without waiting for a clk edge.
